// File: rtl/mem_rr_arbiter_if.sv
// mem_rr_arbiter_if
// Bundles everything that passes between the two requesters, the arbiter and
// the single-port memory behind it.
//
//   req_valid  [1:0]         per-requester request valid (bit i = requester i)
//   req_we     [1:0]         per-requester 1 = write, 0 = read
//   req_addr   [2*AW-1:0]    requester i address in [i*AW +: AW]
//   req_wdata  [2*DW-1:0]    requester i write data in [i*DW +: DW]
//   req_ready  [1:0]         one-hot grant from the arbiter
//   rsp_valid  [1:0]         one-cycle read-response pulse, tagged by requester
//   rsp_rdata  [DW-1:0]      read data while a rsp_valid bit is high
//   init_done                high once the zero-fill sweep has completed
//   mem_addr   [AW-1:0]      memory address
//   mem_we                   memory write enable
//   mem_wdata  [DW-1:0]      memory write data
//   mem_rdata  [DW-1:0]      memory combinational read data
//
// Modports:
//   slave  - the arbiter's view
//   master - the view of the requesters plus the memory instance
interface mem_rr_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    logic [1:0]              req_valid;
    logic [1:0]              req_we;
    logic [2*ADDR_WIDTH-1:0] req_addr;
    logic [2*DATA_WIDTH-1:0] req_wdata;
    logic [1:0]              req_ready;
    logic [1:0]              rsp_valid;
    logic [DATA_WIDTH-1:0]   rsp_rdata;
    logic                    init_done;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, init_done,
               mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, init_done,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
// Sits directly in front of a single-port memory (synchronous write,
// combinational read) and shares it between two requesters. After reset it
// zero-fills the whole memory, one word per cycle. It then grants one
// request per cycle, round-robin on ties. Reads return data two cycles after
// the handshake.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-low reset (0 = reset)
//   bus  - mem_rr_arbiter_if.slave, carrying the request/response handshake
//          and the memory addr/we/wdata/rdata signals
module mem_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic               clk,
    input  logic               rst,
    mem_rr_arbiter_if.slave    bus
);

    localparam int                CNT_WIDTH = ADDR_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] SWEEP_END = CNT_WIDTH'(DEPTH);

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    state_e                  state_q,     state_d;
    logic [CNT_WIDTH-1:0]    sweepCount_q, sweepCount_d;
    logic                    initDone_q,  initDone_d;
    logic [ADDR_WIDTH-1:0]   memAddr_q,   memAddr_d;
    logic                    memWe_q,     memWe_d;
    logic [DATA_WIDTH-1:0]   memWdata_q,  memWdata_d;
    logic                    lastGrant_q, lastGrant_d;
    logic                    pendValid_q, pendValid_d;
    logic                    pendIdx_q,   pendIdx_d;
    logic [1:0]              rspValid_q,  rspValid_d;
    logic [DATA_WIDTH-1:0]   rspRdata_q,  rspRdata_d;

    logic [1:0]              grant;
    logic                    selWe;
    logic [ADDR_WIDTH-1:0]   selAddr;
    logic [DATA_WIDTH-1:0]   selWdata;

    // Round-robin grant: a lone requester always wins. On a tie the
    // requester that did not win last time is served, so neither can
    // starve the other. No grant at all outside RUN.
    always_comb begin
        grant = 2'b00;
        if (state_q == RUN) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = lastGrant_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Select the granted requester's fields. grant[1] doubles as the
    // winner's index because the grant is one-hot.
    always_comb begin
        selWe    = grant[1] ? bus.req_we[1] : bus.req_we[0];
        selAddr  = grant[1] ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                            : bus.req_addr[ADDR_WIDTH-1:0];
        selWdata = grant[1] ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                            : bus.req_wdata[DATA_WIDTH-1:0];
    end

    // Next-state logic. The sweep counter counts issued zero-writes. Once it
    // reaches DEPTH, the write to DEPTH-1 has been on the bus for a full
    // cycle, so the block can move to RUN. In RUN a handshake registers the
    // access for the memory. A read additionally leaves a pending tag, so
    // the following cycle captures mem_rdata into the response registers.
    always_comb begin
        state_d      = state_q;
        sweepCount_d = sweepCount_q;
        initDone_d   = initDone_q;
        memAddr_d    = memAddr_q;
        memWe_d      = 1'b0;
        memWdata_d   = memWdata_q;
        lastGrant_d  = lastGrant_q;
        pendValid_d  = 1'b0;
        pendIdx_d    = pendIdx_q;
        rspValid_d   = 2'b00;
        rspRdata_d   = '0;

        if (pendValid_q) begin
            rspValid_d = pendIdx_q ? 2'b10 : 2'b01;
            rspRdata_d = bus.mem_rdata;
        end

        case (state_q)
            INIT: begin
                if (sweepCount_q == SWEEP_END) begin
                    state_d    = RUN;
                    initDone_d = 1'b1;
                end else begin
                    memAddr_d    = sweepCount_q[ADDR_WIDTH-1:0];
                    memWe_d      = 1'b1;
                    memWdata_d   = '0;
                    sweepCount_d = sweepCount_q + 1'b1;
                end
            end
            RUN: begin
                if (grant != 2'b00) begin
                    memAddr_d   = selAddr;
                    memWe_d     = selWe;
                    memWdata_d  = selWe ? selWdata : '0;
                    lastGrant_d = grant[1];
                    pendValid_d = ~selWe;
                    pendIdx_d   = grant[1];
                end
            end
            default: state_d = INIT;
        endcase
    end

    // State register. Reset drops any in-flight response and restarts the
    // sweep from address 0. lastGrant resets to 1 so that requester 0 wins
    // the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= INIT;
            sweepCount_q <= '0;
            initDone_q   <= 1'b0;
            memAddr_q    <= '0;
            memWe_q      <= 1'b0;
            memWdata_q   <= '0;
            lastGrant_q  <= 1'b1;
            pendValid_q  <= 1'b0;
            pendIdx_q    <= 1'b0;
            rspValid_q   <= 2'b00;
            rspRdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            sweepCount_q <= sweepCount_d;
            initDone_q   <= initDone_d;
            memAddr_q    <= memAddr_d;
            memWe_q      <= memWe_d;
            memWdata_q   <= memWdata_d;
            lastGrant_q  <= lastGrant_d;
            pendValid_q  <= pendValid_d;
            pendIdx_q    <= pendIdx_d;
            rspValid_q   <= rspValid_d;
            rspRdata_q   <= rspRdata_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rspValid_q;
    assign bus.rsp_rdata = rspRdata_q;
    assign bus.init_done = initDone_q;
    assign bus.mem_addr  = memAddr_q;
    assign bus.mem_we    = memWe_q;
    assign bus.mem_wdata = memWdata_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter
// Bench for mem_rr_arbiter with a small memory (DEPTH=16). A behavioural
// memory is attached to the mem_* signals. The reference model treats the
// memory as a plain array that is updated in the order the model grants
// requests. Each accepted read queues an expected response, due two cycles
// after its handshake.
module tb_mem_rr_arbiter;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mem_rr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_rr_arbiter #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Memory behind the arbiter: synchronous write, combinational read.
    logic [DW-1:0] tbMem [0:DEPTH-1];

    always @(posedge clk) begin
        if (bus.mem_we)
            tbMem[bus.mem_addr] <= bus.mem_wdata;
    end

    assign bus.mem_rdata = tbMem[bus.mem_addr];

    // Reference model state.
    typedef struct {
        int            due;
        logic [1:0]    who;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0] refMem [0:DEPTH-1];
    rsp_t          expRsp [$];
    int            modelLast;
    int            cyc;
    int            checks = 0;
    int            errors = 0;

    // Compares one observed value against its expected value and logs a
    // mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     tag, observed, expected, $time);
        end
    endtask

    // Restores the model to the state the design reaches after a reset
    // followed by a completed sweep.
    task automatic resetModel();
        for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
        expRsp.delete();
        modelLast = 1;
        cyc       = 0;
    endtask

    // Called mid-cycle, with this cycle's inputs already applied. It checks
    // the grant and any response due now, then commits the granted access
    // to the model.
    task automatic stepModel();
        int            g;
        logic [1:0]    expReady;
        logic [AW-1:0] a;
        rsp_t          r;
        case (bus.req_valid)
            2'b01:   g = 0;
            2'b10:   g = 1;
            2'b11:   g = 1 - modelLast;
            default: g = -1;
        endcase
        expReady = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
        checkOutput("req_ready", 32'(bus.req_ready), 32'(expReady));

        if (expRsp.size() > 0 && expRsp[0].due == cyc) begin
            checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(expRsp[0].who));
            checkOutput("rsp_rdata", 32'(bus.rsp_rdata), 32'(expRsp[0].data));
            void'(expRsp.pop_front());
        end else begin
            checkOutput("rsp_valid_idle", 32'(bus.rsp_valid), 32'(0));
        end

        if (g >= 0) begin
            modelLast = g;
            a = bus.req_addr[g*AW +: AW];
            if (bus.req_we[g]) begin
                refMem[a] = bus.req_wdata[g*DW +: DW];
            end else begin
                r.due  = cyc + 2;
                r.who  = (g == 0) ? 2'b01 : 2'b10;
                r.data = refMem[a];
                expRsp.push_back(r);
            end
        end
    endtask

    // Drives one cycle of requests just after a rising edge and checks them
    // at the falling edge.
    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] we,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = {a1, a0};
        bus.req_wdata = {d1, d0};
        @(negedge clk);
        stepModel();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mem_addr"},  32'(bus.mem_addr),  32'(0));
        checkOutput({tag, "_mem_we"},    32'(bus.mem_we),    32'(0));
        checkOutput({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(0));
        checkOutput({tag, "_req_ready"}, 32'(bus.req_ready), 32'(0));
        checkOutput({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(0));
        checkOutput({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'(0));
        checkOutput({tag, "_init_done"}, 32'(bus.init_done), 32'(0));
    endtask

    // Expects exactly DEPTH zero-writes to addresses 0..DEPTH-1, with both
    // requesters asking the whole time and never being granted. init_done
    // must rise in the following cycle.
    task automatic checkSweep();
        bus.req_valid = 2'b11;
        bus.req_we    = 2'($urandom);
        bus.req_addr  = 8'($urandom);
        bus.req_wdata = 16'($urandom);
        for (int k = 0; k < DEPTH; k++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("sweep_we",    32'(bus.mem_we),    32'(1));
            checkOutput("sweep_addr",  32'(bus.mem_addr),  32'(k));
            checkOutput("sweep_wdata", 32'(bus.mem_wdata), 32'(0));
            checkOutput("sweep_ready", 32'(bus.req_ready), 32'(0));
            checkOutput("sweep_rsp",   32'(bus.rsp_valid), 32'(0));
            checkOutput("sweep_done",  32'(bus.init_done), 32'(0));
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput("init_done_rise", 32'(bus.init_done), 32'(1));
        checkOutput("post_sweep_we",  32'(bus.mem_we),    32'(0));
        bus.req_valid = 2'b00;
        @(posedge clk);
        #1;
        resetModel();
    endtask

    task automatic randomCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(2'($urandom_range(0, 3)), 2'($urandom),
                          AW'($urandom_range(0, DEPTH-1)),
                          AW'($urandom_range(0, DEPTH-1)),
                          DW'($urandom), DW'($urandom));
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
    endtask

    // Global time bound so the run always reaches a conclusion.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        bus.req_valid = 2'b11;
        bus.req_we    = 2'b11;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        resetModel();

        #12;
        checkAllZero("reset");
        @(posedge clk);
        #2;
        rst = 1'b1;
        checkSweep();

        $display("[TB] directed write/read, tie-break and forwarding");
        idleCycles(1);
        applyStimulus(2'b01, 2'b01, 4'd5, 4'd0, 8'hA5, 8'h00);
        applyStimulus(2'b01, 2'b00, 4'd5, 4'd0, 8'h00, 8'h00);
        applyStimulus(2'b10, 2'b00, 4'd0, 4'd3, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++)
            applyStimulus(2'b11, 2'b00, AW'(i), AW'(i + 4), 8'h00, 8'h00);
        applyStimulus(2'b01, 2'b01, 4'd7, 4'd0, 8'h3C, 8'h00);
        applyStimulus(2'b10, 2'b00, 4'd0, 4'd7, 8'h00, 8'h00);
        idleCycles(3);

        $display("[TB] randomized traffic");
        randomCycles(300);
        idleCycles(3);
        checkOutput("drain1", 32'(expRsp.size()), 32'(0));

        $display("[TB] asynchronous reset during a pending read");
        applyStimulus(2'b01, 2'b01, 4'd5, 4'd0, 8'h5A, 8'h00);
        applyStimulus(2'b01, 2'b00, 4'd5, 4'd0, 8'h00, 8'h00);
        bus.req_valid = 2'b00;
        #2;
        rst = 1'b0;
        #1;
        checkAllZero("midreset");
        @(posedge clk);
        @(negedge clk);
        checkOutput("dropped_rsp", 32'(bus.rsp_valid), 32'(0));
        checkOutput("held_in_reset", 32'(bus.mem_we), 32'(0));
        rst = 1'b1;
        checkSweep();

        applyStimulus(2'b01, 2'b00, 4'd5, 4'd0, 8'h00, 8'h00);
        randomCycles(60);
        idleCycles(3);
        checkOutput("drain2", 32'(expRsp.size()), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Shares one single-port synchronous-write, combinational-read memory (DATA_WIDTH x DEPTH) between two requesters.
- After reset, runs a zero-fill sweep, because the memory's own clear is synchronous and slow. It then arbitrates read/write requests round-robin, one access per cycle.
- Sits directly in front of the memory instance. It is the only driver of the memory's addr/we/data_input.

Parameters:
DATA_WIDTH, 8, word width
DEPTH, 1024, number of memory words
ADDR_WIDTH, 10, address width; must satisfy 2**ADDR_WIDTH >= DEPTH

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
req_valid  input  2  per-requester request valid (bit i = requester i)
req_we  input  2  per-requester 1 = write, 0 = read
req_addr  input  2*ADDR_WIDTH  requester i address in bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  2*DATA_WIDTH  requester i write data in bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  output  2  one-hot grant; handshake when req_valid[i] & req_ready[i]
rsp_valid  output  2  one-cycle pulse: read data for requester i on rsp_rdata
rsp_rdata  output  DATA_WIDTH  read data, valid only while a rsp_valid bit is high
init_done  output  1  high once the zero-fill sweep has completed
mem_addr  output  ADDR_WIDTH  to memory addr (zero-extended at integration)
mem_we  output  1  to memory we
mem_wdata  output  DATA_WIDTH  to memory data_input
mem_rdata  input  DATA_WIDTH  from memory data_output

Behaviour:
- Reset (rst = 0, asynchronous):
  - State goes to INIT.
  - All outputs are 0: mem_addr, mem_we, mem_wdata, req_ready, rsp_valid, rsp_rdata, init_done.
  - Internal: sweep counter = 0, last_grant = 1 (so requester 0 wins the first tie), read-pending flags clear.
- INIT state:
  - Each cycle drives mem_we=1, mem_wdata=0, mem_addr=counter, then increments counter.
  - After the cycle with mem_addr = DEPTH-1: go to RUN, set init_done=1, set mem_we=0.
  - Sweep takes exactly DEPTH write cycles.
  - req_ready = 0 throughout.
- RUN state, arbitration (combinational):
  - req_ready is 0 while not in RUN.
  - Only requester i valid: req_ready = one-hot i.
  - Both valid: grant goes to the requester != last_grant.
  - Neither valid: req_ready = 0.
  - Exactly one access is granted per cycle; one requester cannot starve the other.
- Issue stage: on a handshake at edge N, at edge N+1 the block registers:
  - mem_addr = granted address
  - mem_we = granted we
  - mem_wdata = granted wdata (reads drive 0)
  - last_grant = granted index
  - if a read: a pending flag tagged with the requester index
  - With no handshake, mem_we = 0 at that edge; mem_addr and mem_wdata hold.
- Response stage: during the cycle after issue, the block samples mem_rdata for a pending read.
  - rsp_rdata and rsp_valid[i] are registered on the next edge.
  - Read latency: request handshake cycle N -> rsp_valid pulse in cycle N+2, lasting one cycle.
  - Writes produce no response. A write is committed in memory at the edge ending cycle N+1.
- Back-to-back: a new request can be accepted every cycle.
  - A read at the same address as a write accepted one cycle earlier returns the new data, because the write commits before the read's sampling cycle.
- Address range: addresses >= DEPTH are passed through unchanged. Their behaviour is owned by the memory and not checked here.
- Reset mid-operation:
  - In-flight responses are dropped (rsp_valid = 0).
  - mem_we drops to 0 immediately.
  - The sweep restarts from address 0.
  - init_done stays low until the restarted sweep completes.
- req_* inputs are ignored outside RUN. The block never drives X or Z on any output.

Test Plan:
- Reset then idle, DEPTH=16 -> mem_we=1 for exactly 16 cycles with mem_addr 0..15 and mem_wdata=0. init_done rises the next cycle; req_ready stays 0 throughout.
- Requester 0 writes addr 5 data 0xA5, then reads addr 5 on the next cycle -> rsp_valid = 2'b01 exactly 2 cycles after the read handshake, with rsp_rdata = 0xA5.
- Both requesters hold valid reads continuously for 6 cycles -> req_ready sequence 01,10,01,10,01,10. Responses alternate 01,10 with 2-cycle latency.
- Requester 1 reads an unwritten addr 3 after init -> rsp_rdata = 0x00 and rsp_valid = 2'b10.
- Requester 0 writes addr 7 = 0x3C; in the next cycle requester 1 reads addr 7 -> requester 1 gets 0x3C.
- Assert rst=0 asynchronously (between edges) during a pending read -> outputs are 0 immediately, the response is never delivered, and a full sweep re-runs before init_done=1.
